// File: rtl/bp_update_ctrl.sv
// Branch predictor write-port scheduler.
// Resolved branches from EX are checked for misprediction (redirect + flush
// window), filtered into a small update queue, and drained one write per
// cycle. A bp_clear request takes over the write port for a full-table
// invalidation sweep; the queue keeps filling meanwhile and drains afterwards.
//
// Handshake: a branch transfers on a rising edge where br_valid && br_ready.
// br_ready is a register derived from next-cycle state (queue not full and
// recovery FSM idle); it never depends on this cycle's dequeue, and EX holds
// its branch stable while br_ready is low.
module bp_update_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int BHT_LEN      = 7,
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              br_pred_taken,
    input  logic [ADDR_W-1:0] br_pred_target,
    input  logic              bp_clear,
    output logic              clear_busy,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              change_enable,
    output logic [ADDR_W-1:0] addr_r,
    output logic              jmp_r,
    output logic [ADDR_W-1:0] real_target,
    output logic              rec_state_dbg,
    output logic              port_state_dbg
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {REC_IDLE = 1'b0, REC_RECOVER = 1'b1} rec_state_t;
    typedef enum logic {PORT_DRAIN = 1'b0, PORT_SWEEP = 1'b1} port_state_t;

    rec_state_t  rec_state;
    port_state_t port_state;

    logic [FC_W-1:0]    flush_cnt;
    logic               clear_req;
    logic [BHT_LEN-1:0] sweep_idx;

    logic [ADDR_W-1:0] q_pc     [QDEPTH];
    logic              q_taken  [QDEPTH];
    logic [ADDR_W-1:0] q_target [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              mispredict;
    logic              enq;
    logic              deq;
    logic [CNT_W-1:0]  count_next;
    logic              rec_idle_next;
    logic [ADDR_W-1:0] sweep_addr;

    assign accept     = br_valid && br_ready;
    assign mispredict = (br_taken != br_pred_taken) ||
                        (br_taken && (br_target != br_pred_target));
    // Only branches that are or were believed taken carry useful BTB state.
    assign enq        = accept && (br_taken || br_pred_taken);
    // The port is handed to the sweep on the edge clear_req is seen, so no
    // dequeue may happen on that edge.
    assign deq        = (port_state == PORT_DRAIN) && !clear_req && (count != '0);
    assign count_next = count + CNT_W'(enq) - CNT_W'(deq);

    assign rec_idle_next = ((rec_state == REC_IDLE) && !(accept && mispredict)) ||
                           ((rec_state == REC_RECOVER) && (flush_cnt == '0));

    assign sweep_addr = {{(ADDR_W-BHT_LEN-2){1'b0}}, sweep_idx, 2'b00};

    assign rec_state_dbg  = (rec_state == REC_RECOVER);
    assign port_state_dbg = (port_state == PORT_SWEEP);

    // Update queue storage: written at the tail on every enqueue.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]     <= br_pc;
            q_taken[wr_ptr]  <= br_taken;
            q_target[wr_ptr] <= br_target;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Recovery FSM: redirect pulse, flush window and accept gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_state      <= REC_IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            br_ready       <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            br_ready       <= rec_idle_next && (count_next != CNT_W'(QDEPTH));
            case (rec_state)
                REC_IDLE: begin
                    if (accept && mispredict) begin
                        rec_state      <= REC_RECOVER;
                        flush          <= 1'b1;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
                        redirect_valid <= 1'b1;
                        redirect_pc    <= br_taken ? br_target : (br_pc + ADDR_W'(4));
                    end
                end
                REC_RECOVER: begin
                    if (flush_cnt == '0) begin
                        rec_state <= REC_IDLE;
                        flush     <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: rec_state <= REC_IDLE;
            endcase
        end
    end

    // Write-port FSM: drain queued updates or run the invalidation sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_state    <= PORT_DRAIN;
            clear_req     <= 1'b0;
            clear_busy    <= 1'b0;
            sweep_idx     <= '0;
            change_enable <= 1'b0;
            addr_r        <= '0;
            jmp_r         <= 1'b0;
            real_target   <= '0;
        end else begin
            // Busy covers the pending request, the sweep itself, and the
            // cycle showing the last sweep write.
            clear_busy <= (bp_clear && !clear_busy) || clear_req ||
                          (port_state == PORT_SWEEP);
            if (bp_clear && !clear_busy) clear_req <= 1'b1;
            case (port_state)
                PORT_DRAIN: begin
                    if (clear_req) begin
                        port_state    <= PORT_SWEEP;
                        clear_req     <= 1'b0;
                        sweep_idx     <= '0;
                        change_enable <= 1'b0;
                    end else if (count != '0) begin
                        change_enable <= 1'b1;
                        addr_r        <= q_pc[rd_ptr];
                        jmp_r         <= q_taken[rd_ptr];
                        real_target   <= q_target[rd_ptr];
                    end else begin
                        change_enable <= 1'b0;
                    end
                end
                PORT_SWEEP: begin
                    change_enable <= 1'b1;
                    addr_r        <= sweep_addr;
                    jmp_r         <= 1'b0;
                    real_target   <= '0;
                    if (sweep_idx == {BHT_LEN{1'b1}}) begin
                        port_state <= PORT_DRAIN;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                default: port_state <= PORT_DRAIN;
            endcase
        end
    end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Scheduler for the branch predictor's single write port (addr_r / jmp_r / real_target / change_enable).
- Accepts resolved branches from EX and detects mispredictions. Issues the fetch redirect and a wrong-path flush window.
- Queues predictor updates and drains them one per cycle.
- Arbitrates the write port between queued updates and a full-table invalidation sweep requested by fence.i.

Parameters:
- ADDR_W, 32, address width.
- BHT_LEN, 7, predictor index bits; table has 2**BHT_LEN entries, indexed by pc[BHT_LEN+1:2].
- QDEPTH, 4, update queue depth (power of two, >=2).
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- br_valid  in  1  EX presents a resolved branch/jump.
- br_ready  out  1  controller accepts the branch this cycle.
- br_pc  in  ADDR_W  pc of the branch.
- br_taken  in  1  actual direction.
- br_target  in  ADDR_W  actual taken target.
- br_pred_taken  in  1  prediction carried with the instruction.
- br_pred_target  in  ADDR_W  predicted target carried with the instruction.
- bp_clear  in  1  one-cycle request to invalidate the whole predictor.
- clear_busy  out  1  sweep pending or in progress.
- redirect_valid  out  1  one-cycle pulse, fetch restarts at redirect_pc.
- redirect_pc  out  ADDR_W  corrected fetch address.
- flush  out  1  squash wrong-path instructions in IF/ID/EX.
- change_enable  out  1  predictor write strobe.
- addr_r  out  ADDR_W  predictor write address.
- jmp_r  out  1  predictor write direction/valid.
- real_target  out  ADDR_W  predictor write target.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - Queue empty; recovery FSM in IDLE; port FSM in DRAIN; sweep request cleared.
  - Reset mid-sweep aborts the sweep; a partially cleared table is acceptable.
- Accept:
  - br_ready = !queue_full && rec_state==IDLE, from registered state only; no same-cycle dequeue bypass.
  - A branch is accepted on an edge where br_valid && br_ready.
  - While br_ready=0, EX holds its branch stable.
- Mispredict on an accepted branch: (br_taken != br_pred_taken) || (br_taken && br_target != br_pred_target).
  - On that edge, redirect_valid=1 is registered for exactly one cycle.
  - redirect_pc = br_taken ? br_target : br_pc+4, with mod 2**ADDR_W wrap.
  - flush goes high in the same cycle and the recovery FSM enters RECOVER.
- Recovery FSM:
  - IDLE -> RECOVER on a mispredict.
  - RECOVER holds flush=1 for FLUSH_CYCLES cycles, counted from the redirect cycle, then returns to IDLE.
  - In RECOVER, br_ready=0 and br_valid is ignored (wrong path).
- Enqueue filter: an accepted branch is queued iff br_taken || br_pred_taken. Entry = {pc, taken, target}.
  - Not-taken, not-predicted branches produce no write.
  - The filter is independent of mispredict; the branch that triggered a redirect is still queued.
- Port FSM, DRAIN:
  - If the queue is non-empty, dequeue the oldest entry each cycle.
  - The entry drives change_enable=1, addr_r=pc, jmp_r=taken, real_target=target in the cycle after dequeue (registered outputs).
  - Otherwise change_enable=0.
  - An entry accepted on edge N is written no earlier than the cycle after edge N+1.
  - FIFO order is preserved. Simultaneous enqueue and dequeue keeps the count.
  - Full (count==QDEPTH) forces br_ready=0.
- bp_clear:
  - Sets a sticky request; clear_busy=1 from the next cycle.
  - At the next edge where the port FSM is in DRAIN, it enters SWEEP.
  - An in-flight registered write completes first.
  - bp_clear while already busy is ignored (no restart).
- SWEEP:
  - Index i runs 0..2**BHT_LEN-1, one per cycle.
  - Each cycle drives change_enable=1, addr_r={0, i, 2'b00}, jmp_r=0, real_target=0.
  - The queue is not drained but keeps accepting until full. Redirect/flush logic is unaffected.
  - After the last index: return to DRAIN; clear_busy drops in the cycle after the last sweep write.
  - Queued entries then drain normally.
- Simultaneous events:
  - Mispredict and bp_clear on the same edge: both take effect.
  - Enqueue on the same edge as sweep entry: the entry is queued.

Test Plan:
- Correct prediction: pc=0x100, taken, target=0x200, predicted taken to 0x200 -> no redirect, flush=0; two cycles later change_enable=1, addr_r=0x100, jmp_r=1, real_target=0x200.
- Direction mispredict: pc=0x40, not taken, pred_taken=1 -> redirect_valid pulse with redirect_pc=0x44; flush high 2 cycles; br_ready=0 both cycles; write jmp_r=0 to 0x40.
- Target mispredict: pc=0x80, taken to 0x300, predicted 0x280 -> redirect_pc=0x300; a br_valid offered during RECOVER is never accepted or written.
- Not-taken, not-predicted: pc=0x10 -> no write, no redirect.
- Back-pressure: inject 6 predicted-correct taken branches during a sweep with QDEPTH=4 -> br_ready low after 4; after the sweep, 4 writes in order, then the remaining 2.
- Sweep: bp_clear pulse with BHT_LEN=7 -> 128 consecutive writes, addr_r 0x000..0x1FC step 4, jmp_r=0; clear_busy deasserts after. Assert rst low at index 50 -> all outputs 0 immediately, no further writes.
